// File: rtl/regfile_mp_sb_if.sv
// rtl/regfile_mp_sb_if.sv - read, write and allocate bus bundle for the multi-port register file
interface regfile_mp_sb_if #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int AW     = $clog2(NREGS)
);
  logic [NUM_RD*AW-1:0]   rs_addr_i;
  logic [NUM_RD*XLEN-1:0] rs_data_o;
  logic [NUM_RD-1:0]      rs_busy_o;
  logic [NUM_WR-1:0]      wr_en_i;
  logic [NUM_WR*AW-1:0]   wr_addr_i;
  logic [NUM_WR*XLEN-1:0] wr_data_i;
  logic                   alloc_en_i;
  logic [AW-1:0]          alloc_addr_i;
  logic                   alloc_ready_o;
  logic [NREGS-1:0]       busy_vec_o;

  modport master (
    output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i,
    input  rs_data_o, rs_busy_o, alloc_ready_o, busy_vec_o
  );

  modport slave (
    input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i,
    output rs_data_o, rs_busy_o, alloc_ready_o, busy_vec_o
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with pending-write scoreboard
// x0 and out-of-range addresses never match any stored entry, so they read 0 and ignore updates.
module regfile_mp_sb #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_sync,
  regfile_mp_sb_if.slave  bus
);
  localparam int NSLOT = 1 << AW;

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] busy;

  logic [NREGS-1:1] wr_hit;
  logic [XLEN-1:0]  wr_val [1:NREGS-1];
  logic [NREGS-1:1] alloc_set;
  logic [NSLOT-1:0] busy_ext;
  logic [NSLOT-1:0] hit_ext;
  logic             alloc_ready;

  // Ascending port scan: the highest-indexed matching port overrides lower ones.
  always_comb begin
    wr_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      wr_val[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus.wr_en_i[p] && (bus.wr_addr_i[p*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = bus.wr_data_i[p*XLEN +: XLEN];
        end
      end
    end
  end

  assign busy_ext = NSLOT'({busy, 1'b0});
  assign hit_ext  = NSLOT'({wr_hit, 1'b0});

  // A completing write frees its register for a new producer in the same cycle.
  always_comb begin
    alloc_ready = (bus.alloc_addr_i == '0) || !busy_ext[bus.alloc_addr_i] ||
                  hit_ext[bus.alloc_addr_i];
    alloc_set = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.alloc_en_i && alloc_ready && (bus.alloc_addr_i == AW'(r))) begin
        alloc_set[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      busy <= '0;
      for (int r = 1; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
        // A new allocation supersedes the producer completing this cycle.
        busy[r] <= alloc_set[r] | (busy[r] & ~wr_hit[r]);
      end
    end
  end

  always_comb begin
    bus.rs_data_o = '0;
    bus.rs_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (bus.rs_addr_i[k*AW +: AW] == AW'(r)) begin
          if ((BYPASS != 0) && wr_hit[r]) begin
            bus.rs_data_o[k*XLEN +: XLEN] = wr_val[r];
            bus.rs_busy_o[k]              = 1'b0;
          end else begin
            bus.rs_data_o[k*XLEN +: XLEN] = regs[r];
            bus.rs_busy_o[k]              = busy[r];
          end
        end
      end
    end
  end

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.busy_vec_o    = {busy, 1'b0};
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file; successor to the single-write, 2-read 64-bit register file.
- Adds configurable width, depth, read-port and write-port counts, and optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard (busy bits) so issue logic can detect RAW and WAW hazards.
- Sits between decode/issue (reads, allocation) and writeback (writes).

Parameters:
- XLEN, 64, data width in bits.
- NREGS, 32, architectural register count, including x0. Legal range 2..64.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to reads and to busy status; 0 = no forwarding.
- AW, $clog2(NREGS), register address width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_sync  in  1  synchronous active-high reset.
- rs_addr_i  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rs_data_o  out  NUM_RD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rs_busy_o  out  NUM_RD  1 = the register read on port k has a write pending.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*AW  write addresses.
- wr_data_i  in  NUM_WR*XLEN  write data.
- alloc_en_i  in  1  issue request: mark alloc_addr_i as pending-write.
- alloc_addr_i  in  AW  destination register being allocated.
- alloc_ready_o  out  1  1 = the allocation is accepted this cycle.
- busy_vec_o  out  NREGS  raw scoreboard state; bit 0 is always 0.

Behaviour:
- Reset (reset_sync=1 at a clk edge): every register cleared to 0; every busy bit cleared.
  - Reset overrides any write or allocation in the same cycle.
  - After reset: all rs_data_o = 0, rs_busy_o = 0, busy_vec_o = 0, and alloc_ready_o = 1 for any alloc_addr_i.
- Register x0: always reads 0; never busy. Writes and allocations targeting x0 are ignored.
- Out-of-range addresses (>= NREGS, possible only when NREGS is not a power of 2):
  - Reads return 0 with busy 0.
  - Writes and allocations are ignored.
- Reads: combinational, zero cycles of latency.
  - BYPASS=1: if any enabled write port targets the read address this cycle, the read returns that port's wr_data_i. Otherwise it returns the stored value.
  - BYPASS=0: reads always return the stored value; a write becomes visible the cycle after its edge.
- Writes: take effect at the clk edge.
  - Multiple enabled ports targeting the same address: the highest-indexed port wins, for both the stored value and the bypassed value.
- Scoreboard:
  - Set: busy[a] is set at the edge when alloc_en_i && alloc_ready_o && a != 0.
  - Clear: busy[a] is cleared at the edge when any enabled write port targets a.
  - Simultaneous set and clear on the same a: set wins, because the new producer supersedes the completing one.
  - alloc_ready_o = (alloc_addr_i == 0) || !busy[alloc_addr_i] || (a write to alloc_addr_i occurs this cycle). It is combinational, and a completing write frees the register in the same cycle.
  - alloc_en_i while alloc_ready_o = 0 is ignored with no state change. Issue logic must stall (WAW protection).
  - rs_busy_o[k]:
    - BYPASS=1: busy[rs_addr_k] masked by a same-cycle write to rs_addr_k.
    - BYPASS=0: raw busy[rs_addr_k].
  - A write to a non-busy register is legal: the data is stored and busy stays 0.
- busy_vec_o reflects registered state only, with no bypass masking.
- Implementation: no internal pipeline; storage and busy bits are flops. The module is synthesizable for any legal parameter set.

Test Plan:
- Reset then read: assert reset_sync for 1 cycle, read x5 and x31 -> rs_data_o = 0, rs_busy_o = 0, busy_vec_o = 0.
- Write/read with BYPASS=1: wr port0 x7 = 0xDEAD_BEEF while port1 reads x7 in the same cycle -> rs_data_o = 0xDEAD_BEEF that cycle and on later cycles.
  - Same stimulus with BYPASS=0 -> old value 0 that cycle, 0xDEAD_BEEF next cycle.
- Write collision: port0 writes x3 = 0x11 and port1 writes x3 = 0x22 in the same cycle -> x3 reads 0x22.
- x0 protection: write x0 = 0xFFFF, alloc x0 -> x0 reads 0, busy_vec_o[0] = 0, alloc_ready_o = 1.
- Scoreboard: alloc x9 -> busy_vec_o[9] = 1 next cycle.
  - Second alloc x9 with no write -> alloc_ready_o = 0, no state change.
  - Write x9 together with alloc x9 in the same cycle -> alloc_ready_o = 1, busy_vec_o[9] stays 1, x9 data updated.
- Reset mid-operation: with x4 busy and holding 0x55, assert reset_sync while a write to x4 occurs -> x4 = 0 and busy_vec_o = 0 after the edge.
